// File: rtl/two_input_or_pkg.sv
// Shared constants for the two-input OR fault-modelling leaf: diagnosis codes,
// per-pattern mismatch weights, BIST FSM state encoding and fault line indices.
package two_input_or_pkg;

   // Diagnosis codes latched into diag_code
   localparam logic [2:0] ALL_OK         = 3'd0;
   localparam logic [2:0] SA1_SOME_LINE  = 3'd1;
   localparam logic [2:0] B_SA0          = 3'd2;
   localparam logic [2:0] A_SA0          = 3'd3;
   localparam logic [2:0] MULTI_OR_Z_SA0 = 3'd4;

   // Weight added when the pattern (a,b) sees a wrong Z
   localparam logic [2:0] W00 = 3'd1;
   localparam logic [2:0] W01 = 3'd2;
   localparam logic [2:0] W10 = 3'd3;
   localparam logic [2:0] W11 = 3'd4;

   // BIST FSM states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_P00  = 3'd1;
   localparam state_t ST_P01  = 3'd2;
   localparam state_t ST_P10  = 3'd3;
   localparam state_t ST_P11  = 3'd4;
   localparam state_t ST_DIAG = 3'd5;

   // Bit positions in inj_mask / inj_val
   localparam int LINE_A = 0;
   localparam int LINE_B = 1;
   localparam int LINE_Z = 2;

endpackage

// File: rtl/two_input_or_stuck_at_mux.sv
// Stuck-at fault injector for one line: passes the signal through unless the
// line's mask bit is set, in which case the stuck value replaces it.
module stuck_at_mux (
   input  logic in,
   input  logic mask,
   input  logic val,
   output logic out
);

   // Fault override has priority over the live signal
   always_comb out = mask ? val : in;

endmodule

// File: rtl/two_input_or.sv
// Two-input OR with stuck-at fault injection on A, B and Z, a weighted mismatch
// score, a score-to-diagnosis decoder and a 4-pattern built-in self-test.
module two_input_or
   import two_input_or_pkg::*;
#(
   parameter int SCORE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               A,
   input  logic               B,
   output logic               Z,
   input  logic [2:0]         inj_mask,
   input  logic [2:0]         inj_val,
   input  logic               chk_valid,
   input  logic               chk_clear,
   input  logic               diag_req,
   input  logic               bist_start,
   output logic               bist_busy,
   output logic               fault_flag,
   output logic [SCORE_W-1:0] fault_score,
   output logic [2:0]         diag_code,
   output logic               diag_valid
);

   localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

   state_t             state;
   logic               a, b, a_f, b_f, z_ideal, z_core;
   logic               idle, pat_state, do_chk, mismatch;
   logic [2:0]         weight;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W-1:0] score_add, score_nxt;
   logic [2:0]         diag_nxt;

   // Ideal operands come from the pins in IDLE, from the BIST pattern otherwise
   always_comb begin
      idle      = (state == ST_IDLE);
      pat_state = (state == ST_P00) || (state == ST_P01) ||
                  (state == ST_P10) || (state == ST_P11);
      a = A;
      b = B;
      unique case (state)
         ST_P00:  begin a = 1'b0; b = 1'b0; end
         ST_P01:  begin a = 1'b0; b = 1'b1; end
         ST_P10:  begin a = 1'b1; b = 1'b0; end
         ST_P11:  begin a = 1'b1; b = 1'b1; end
         ST_DIAG: begin a = 1'b0; b = 1'b0; end
         default: ;
      endcase
      z_ideal = a | b;
   end

   stuck_at_mux u_mux_a (.in(a),         .mask(inj_mask[LINE_A]), .val(inj_val[LINE_A]), .out(a_f));
   stuck_at_mux u_mux_b (.in(b),         .mask(inj_mask[LINE_B]), .val(inj_val[LINE_B]), .out(b_f));
   always_comb z_core = a_f | b_f;
   stuck_at_mux u_mux_z (.in(z_core),    .mask(inj_mask[LINE_Z]), .val(inj_val[LINE_Z]), .out(Z));

   // Mismatch detection, weighted saturating accumulation and diagnosis decode
   always_comb begin
      do_chk   = pat_state || (idle && chk_valid && !chk_clear);
      mismatch = do_chk && (Z != z_ideal);
      unique case ({a, b})
         2'b00:   weight = W00;
         2'b01:   weight = W01;
         2'b10:   weight = W10;
         default: weight = W11;
      endcase
      sum       = {1'b0, fault_score} + {{(SCORE_W-2){1'b0}}, weight};
      score_add = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
      if (idle && chk_clear) score_nxt = '0;
      else if (mismatch)     score_nxt = score_add;
      else                   score_nxt = fault_score;
      if (score_nxt == SCORE_W'(0))      diag_nxt = ALL_OK;
      else if (score_nxt == SCORE_W'(1)) diag_nxt = SA1_SOME_LINE;
      else if (score_nxt == SCORE_W'(2)) diag_nxt = B_SA0;
      else if (score_nxt == SCORE_W'(3)) diag_nxt = A_SA0;
      else                               diag_nxt = MULTI_OR_Z_SA0;
   end

   always_comb bist_busy = !idle;

   // State, score, flag and diagnosis registers; BIST walks one pattern per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         fault_score <= '0;
         fault_flag  <= 1'b0;
         diag_code   <= ALL_OK;
         diag_valid  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bist_start) begin
                  fault_score <= '0;
                  fault_flag  <= 1'b0;
                  diag_valid  <= 1'b0;
                  state       <= ST_P00;
               end else begin
                  fault_score <= score_nxt;
                  if (chk_clear)     fault_flag <= 1'b0;
                  else if (mismatch) fault_flag <= 1'b1;
                  if (diag_req) begin
                     diag_code  <= diag_nxt;
                     diag_valid <= 1'b1;
                  end else if (score_nxt != fault_score) begin
                     diag_valid <= 1'b0;
                  end
               end
            end
            ST_P00, ST_P01, ST_P10, ST_P11: begin
               fault_score <= score_nxt;
               if (mismatch) fault_flag <= 1'b1;
               if (score_nxt != fault_score) diag_valid <= 1'b0;
               state <= state + 3'd1;
            end
            ST_DIAG: begin
               diag_code  <= diag_nxt;
               diag_valid <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_two_input_or.sv
// Directed bench for two_input_or: a phase-based behavioural model predicts every
// output each cycle, plus literal expectations for each self-test scenario.
module tb_two_input_or;

   logic       clk = 1'b0;
   logic       rst, A, B, chk_valid, chk_clear, diag_req, bist_start;
   logic [2:0] inj_mask, inj_val;
   logic       Z, bist_busy, fault_flag, diag_valid;
   logic [3:0] fault_score;
   logic [2:0] diag_code;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: ph 0 = idle, 1..4 = patterns 00..11, 5 = diagnosis cycle
   int         m_ph    = 0;
   int         m_score = 0;
   logic       m_flag  = 1'b0;
   int         m_dc    = 0;
   logic       m_dv    = 1'b0;
   logic       cmp_en  = 1'b0;

   two_input_or #(.SCORE_W(4)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Z(Z),
      .inj_mask(inj_mask), .inj_val(inj_val),
      .chk_valid(chk_valid), .chk_clear(chk_clear), .diag_req(diag_req),
      .bist_start(bist_start), .bist_busy(bist_busy), .fault_flag(fault_flag),
      .fault_score(fault_score), .diag_code(diag_code), .diag_valid(diag_valid)
   );

   always #5 clk = ~clk;

   function automatic logic faulty_z(input logic a, input logic b);
      logic ap, bp;
      ap = inj_mask[0] ? inj_val[0] : a;
      bp = inj_mask[1] ? inj_val[1] : b;
      return inj_mask[2] ? inj_val[2] : (ap | bp);
   endfunction

   function automatic int decode(input int s);
      return (s <= 3) ? s : 4;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock: predict next model state from current inputs, then commit
   task automatic step();
      int   ph, sc, dc;
      logic fl, dv;
      logic a, b;
      ph = m_ph; sc = m_score; fl = m_flag; dc = m_dc; dv = m_dv;
      if (rst) begin
         ph = 0; sc = 0; fl = 0; dc = 0; dv = 0;
      end else if (m_ph == 0) begin
         if (bist_start) begin
            sc = 0; fl = 0; dv = 0; ph = 1;
         end else begin
            if (chk_clear) begin
               sc = 0; fl = 0;
            end else if (chk_valid && faulty_z(A, B) != (A | B)) begin
               sc = m_score + 1 + 2 * int'(A) + int'(B);
               if (sc > 15) sc = 15;
               fl = 1;
            end
            if (diag_req) begin
               dc = decode(sc); dv = 1;
            end else if (sc != m_score) dv = 0;
         end
      end else if (m_ph <= 4) begin
         a = ((m_ph - 1) & 2) != 0;
         b = ((m_ph - 1) & 1) != 0;
         if (faulty_z(a, b) != (a | b)) begin
            sc = m_score + 1 + 2 * int'(a) + int'(b);
            if (sc > 15) sc = 15;
            fl = 1;
            if (sc != m_score) dv = 0;
         end
         ph = m_ph + 1;
      end else begin
         dc = decode(m_score); dv = 1; ph = 0;
      end
      @(posedge clk);
      m_ph = ph; m_score = sc; m_flag = fl; m_dc = dc; m_dv = dv;
      cmp_en = 1'b1;
      #1;
   endtask

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      logic ez;
      if (cmp_en) begin
         check("score", int'(fault_score), m_score);
         check("flag",  int'(fault_flag),  int'(m_flag));
         check("diag_code", int'(diag_code), m_dc);
         check("diag_valid", int'(diag_valid), int'(m_dv));
         check("busy", int'(bist_busy), int'(m_ph != 0));
         if (m_ph == 0) begin
            ez = faulty_z(A, B);
            check("Z_idle", int'(Z), int'(ez));
         end else if (m_ph <= 4) begin
            ez = faulty_z(((m_ph - 1) & 2) != 0, ((m_ph - 1) & 1) != 0);
            check("Z_bist", int'(Z), int'(ez));
         end
      end
   end

   task automatic run_bist();
      bist_start = 1'b1;
      step();
      bist_start = 1'b0;
      repeat (5) step();
   endtask

   initial begin
      rst = 1'b1; A = 0; B = 0; chk_valid = 0; chk_clear = 0; diag_req = 0;
      bist_start = 0; inj_mask = 3'b000; inj_val = 3'b000;
      step(); step();
      check("rst_score", int'(fault_score), 0);
      check("rst_diag_valid", int'(diag_valid), 0);
      rst = 1'b0;

      // combinational OR truth table, no faults
      for (int i = 0; i < 4; i++) begin
         A = i[1]; B = i[0]; #1;
         check("or_tt", int'(Z), int'(i != 0));
      end

      run_bist();
      check("nofault_score", int'(fault_score), 0);
      check("nofault_diag", int'(diag_code), 0);
      check("nofault_dv", int'(diag_valid), 1);
      check("nofault_busy", int'(bist_busy), 0);

      inj_mask = 3'b001; inj_val = 3'b000; run_bist();
      check("asa0_score", int'(fault_score), 3);
      check("asa0_diag", int'(diag_code), 3);

      inj_mask = 3'b010; run_bist();
      check("bsa0_score", int'(fault_score), 2);
      check("bsa0_diag", int'(diag_code), 2);

      inj_mask = 3'b011; run_bist();
      check("absa0_score", int'(fault_score), 9);
      check("absa0_diag", int'(diag_code), 4);
      check("absa0_flag", int'(fault_flag), 1);

      inj_mask = 3'b100; run_bist();
      check("zsa0_score", int'(fault_score), 9);
      check("zsa0_diag", int'(diag_code), 4);

      // manual check with A stuck at 1
      chk_clear = 1'b1; step(); chk_clear = 1'b0;
      check("clear_score", int'(fault_score), 0);
      check("clear_dv", int'(diag_valid), 0);
      inj_mask = 3'b001; inj_val = 3'b001; A = 0; B = 0; #1;
      check("asa1_z", int'(Z), 1);
      chk_valid = 1'b1; step(); chk_valid = 1'b0;
      check("asa1_score", int'(fault_score), 1);
      diag_req = 1'b1; step(); diag_req = 1'b0;
      check("asa1_diag", int'(diag_code), 1);
      check("asa1_dv", int'(diag_valid), 1);

      // clear has priority over a same-cycle check
      chk_clear = 1'b1; chk_valid = 1'b1; step(); chk_clear = 1'b0;
      check("clr_prio_score", int'(fault_score), 0);
      check("clr_prio_flag", int'(fault_flag), 0);

      // saturation with Z stuck at 0 on pattern 11
      inj_mask = 3'b100; inj_val = 3'b000; A = 1; B = 1;
      repeat (5) step();
      chk_valid = 1'b0;
      check("sat_score", int'(fault_score), 15);

      // reset during P10 of a self-test
      inj_mask = 3'b011; bist_start = 1'b1; step(); bist_start = 1'b0;
      step(); step();
      check("mid_busy", int'(bist_busy), 1);
      rst = 1'b1; step(); rst = 1'b0;
      check("abort_busy", int'(bist_busy), 0);
      check("abort_score", int'(fault_score), 0);
      check("abort_flag", int'(fault_flag), 0);
      check("abort_diag", int'(diag_code), 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
